// File: rtl/issue_pair_scheduler_pkg.sv
// Shared definitions for the dual-issue pair scheduler and the decode-stage
// forwarding block: scheduler FSM encodings, compare-slot indices and the
// RS_SEL_* forwarding mux select codes.
package issue_pair_scheduler_pkg;

  // Scheduler FSM encodings
  typedef enum logic [1:0] {
    SCHED_PAIR    = 2'd0,
    SCHED_SPLIT   = 2'd1,
    SCHED_LDSTALL = 2'd2
  } sched_state_t;

  // Bit positions in the hazard_compare hit vector
  localparam int SCHED_HIT_TRK0 = 0;  // load tracker of lane 0
  localparam int SCHED_HIT_TRK1 = 1;  // load tracker of lane 1
  localparam int SCHED_HIT_PAIR = 2;  // rd of the older slot in the same pair
  localparam int SCHED_NUM_CMP  = 3;

  // Forwarding mux select codes used by the decode-stage operand mux
  localparam logic [1:0] RS_SEL_RF  = 2'd0;
  localparam logic [1:0] RS_SEL_EX  = 2'd1;
  localparam logic [1:0] RS_SEL_MEM = 2'd2;
  localparam logic [1:0] RS_SEL_WB  = 2'd3;

  // Width of a down-counter able to hold the value n (at least one bit)
  function automatic int sched_cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/issue_pair_scheduler_hazard_compare.sv
// Source-vs-destination match for one decode slot. Each of the slot's two
// sources is compared against a small set of candidate destinations; a
// source only participates when it is read and is not x0, a destination only
// when it is written and is not x0.
module hazard_compare
  import issue_pair_scheduler_pkg::*;
#(
  parameter int AW = 5
)(
  input  logic [AW-1:0]                    i_rs1_addr,
  input  logic                             i_rs1_use,
  input  logic [AW-1:0]                    i_rs2_addr,
  input  logic                             i_rs2_use,
  input  logic [SCHED_NUM_CMP-1:0][AW-1:0] i_rd_addr,
  input  logic [SCHED_NUM_CMP-1:0]         i_rd_vld,
  output logic [SCHED_NUM_CMP-1:0]         o_hit
);

  logic w_rs1_act;
  logic w_rs2_act;

  assign w_rs1_act = i_rs1_use && (i_rs1_addr != '0);
  assign w_rs2_act = i_rs2_use && (i_rs2_addr != '0);

  // One hit bit per candidate destination
  always_comb begin
    o_hit = '0;
    for (int k = 0; k < SCHED_NUM_CMP; k++) begin
      o_hit[k] = i_rd_vld[k] && (i_rd_addr[k] != '0) &&
                 ((w_rs1_act && (i_rs1_addr == i_rd_addr[k])) ||
                  (w_rs2_act && (i_rs2_addr == i_rd_addr[k])));
    end
  end

endmodule

// File: rtl/issue_pair_scheduler.sv
// Dual-issue pair scheduler. Decides each cycle which of the two decoded
// instructions enter ID/EX, splits dependent pairs over two cycles and
// inserts load-use bubbles.
//
// Handshake: issue_vld_N is a one-cycle accept of decode slot N into lane N;
// dec_hold=1 means the decode register must present the same pair next
// cycle. There is no back-pressure on issue_vld beyond pipe_stall.
module issue_pair_scheduler
  import issue_pair_scheduler_pkg::*;
#(
  parameter int RF_ADDR_WIDTH   = 5,
  parameter int LOAD_USE_CYCLES = 1
)(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dec_vld_0,
  input  logic                     dec_vld_1,
  input  logic [RF_ADDR_WIDTH-1:0] dec_rs1_addr_0,
  input  logic [RF_ADDR_WIDTH-1:0] dec_rs2_addr_0,
  input  logic [RF_ADDR_WIDTH-1:0] dec_rs1_addr_1,
  input  logic [RF_ADDR_WIDTH-1:0] dec_rs2_addr_1,
  input  logic                     dec_rs1_use_0,
  input  logic                     dec_rs2_use_0,
  input  logic                     dec_rs1_use_1,
  input  logic                     dec_rs2_use_1,
  input  logic [RF_ADDR_WIDTH-1:0] dec_rd_addr_0,
  input  logic [RF_ADDR_WIDTH-1:0] dec_rd_addr_1,
  input  logic                     dec_rd_wen_0,
  input  logic                     dec_rd_wen_1,
  input  logic                     dec_is_load_0,
  input  logic                     dec_is_load_1,
  input  logic                     dec_is_ctrl_0,
  input  logic                     pipe_stall,
  input  logic                     flush,
  output logic                     issue_vld_0,
  output logic                     issue_vld_1,
  output logic                     dec_hold,
  output logic                     split_active,
  output logic [1:0]               dbg_state
);

  localparam int AW = RF_ADDR_WIDTH;
  localparam int CW = sched_cnt_w(LOAD_USE_CYCLES);

  sched_state_t r_state, w_state_nxt, w_eval_state;
  logic         r_ret_split, w_ret_split_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [CW-1:0] r_trk_cnt_0, r_trk_cnt_1;
  logic [AW-1:0] r_trk_rd_0, r_trk_rd_1;

  logic [SCHED_NUM_CMP-1:0][AW-1:0] w_cmp_rd_s0, w_cmp_rd_s1;
  logic [SCHED_NUM_CMP-1:0]         w_cmp_vld_s0, w_cmp_vld_s1;
  logic [SCHED_NUM_CMP-1:0]         w_hit_s0, w_hit_s1;
  logic w_waw, w_split, w_ldu_0, w_ldu_1;
  logic w_iv0, w_iv1, w_hold;

  // Slot 0 sees only the load trackers; slot 1 also sees slot 0's rd
  assign w_cmp_rd_s0  = {{AW{1'b0}}, r_trk_rd_1, r_trk_rd_0};
  assign w_cmp_vld_s0 = {1'b0, (r_trk_cnt_1 != '0), (r_trk_cnt_0 != '0)};
  assign w_cmp_rd_s1  = {dec_rd_addr_0, r_trk_rd_1, r_trk_rd_0};
  assign w_cmp_vld_s1 = {dec_rd_wen_0, (r_trk_cnt_1 != '0), (r_trk_cnt_0 != '0)};

  hazard_compare #(.AW(AW)) u_cmp_s0 (
    .i_rs1_addr (dec_rs1_addr_0),
    .i_rs1_use  (dec_rs1_use_0),
    .i_rs2_addr (dec_rs2_addr_0),
    .i_rs2_use  (dec_rs2_use_0),
    .i_rd_addr  (w_cmp_rd_s0),
    .i_rd_vld   (w_cmp_vld_s0),
    .o_hit      (w_hit_s0)
  );

  hazard_compare #(.AW(AW)) u_cmp_s1 (
    .i_rs1_addr (dec_rs1_addr_1),
    .i_rs1_use  (dec_rs1_use_1),
    .i_rs2_addr (dec_rs2_addr_1),
    .i_rs2_use  (dec_rs2_use_1),
    .i_rd_addr  (w_cmp_rd_s1),
    .i_rd_vld   (w_cmp_vld_s1),
    .o_hit      (w_hit_s1)
  );

  assign w_waw   = dec_rd_wen_0 && dec_rd_wen_1 && (dec_rd_addr_0 != '0) &&
                   (dec_rd_addr_0 == dec_rd_addr_1);
  assign w_split = w_hit_s1[SCHED_HIT_PAIR] || w_waw || dec_is_ctrl_0 ||
                   (dec_is_load_0 && dec_is_load_1);
  // Slot 0 compare never has the pair bit set, so OR of all bits is load-use
  assign w_ldu_0 = |w_hit_s0;
  assign w_ldu_1 = w_hit_s1[SCHED_HIT_TRK0] || w_hit_s1[SCHED_HIT_TRK1];

  // Once the load-use count is exhausted, LDSTALL acts as its originating
  // state in the same cycle so the bubble count equals LOAD_USE_CYCLES.
  assign w_eval_state = (r_state == SCHED_LDSTALL && r_cnt == '0) ?
                        (r_ret_split ? SCHED_SPLIT : SCHED_PAIR) : r_state;

  // Next-state and issue decisions; stall, flush and reset override in order
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_ret_split_nxt = r_ret_split;
    w_iv0           = 1'b0;
    w_iv1           = 1'b0;
    w_hold          = 1'b0;
    case (w_eval_state)
      SCHED_PAIR: begin
        if ((dec_vld_0 && w_ldu_0) || (!dec_vld_0 && dec_vld_1 && w_ldu_1)) begin
          w_hold          = 1'b1;
          w_state_nxt     = SCHED_LDSTALL;
          w_cnt_nxt       = CW'(LOAD_USE_CYCLES - 1);
          w_ret_split_nxt = 1'b0;
        end else if (dec_vld_0 && dec_vld_1 && (w_split || w_ldu_1)) begin
          w_iv0       = 1'b1;
          w_hold      = 1'b1;
          w_state_nxt = SCHED_SPLIT;
        end else begin
          w_iv0       = dec_vld_0;
          w_iv1       = dec_vld_1;
          w_state_nxt = SCHED_PAIR;
        end
      end
      SCHED_SPLIT: begin
        if (w_ldu_1) begin
          w_hold          = 1'b1;
          w_state_nxt     = SCHED_LDSTALL;
          w_cnt_nxt       = CW'(LOAD_USE_CYCLES - 1);
          w_ret_split_nxt = 1'b1;
        end else begin
          w_iv1       = 1'b1;
          w_state_nxt = SCHED_PAIR;
        end
      end
      SCHED_LDSTALL: begin
        w_hold    = 1'b1;
        w_cnt_nxt = r_cnt - 1'b1;
      end
      default: w_state_nxt = SCHED_PAIR;
    endcase
    if (pipe_stall) begin
      w_iv0           = 1'b0;
      w_iv1           = 1'b0;
      w_hold          = 1'b1;
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_ret_split_nxt = r_ret_split;
    end
    if (flush) begin
      w_iv0           = 1'b0;
      w_iv1           = 1'b0;
      w_hold          = 1'b0;
      w_state_nxt     = SCHED_PAIR;
      w_cnt_nxt       = '0;
      w_ret_split_nxt = 1'b0;
    end
    if (rst) begin
      w_iv0  = 1'b0;
      w_iv1  = 1'b0;
      w_hold = 1'b0;
    end
  end

  // FSM state, bubble counter and return-state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= SCHED_PAIR;
      r_cnt       <= '0;
      r_ret_split <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ret_split <= w_ret_split_nxt;
    end
  end

  // Per-lane load trackers: rd of an issued load stays visible for
  // LOAD_USE_CYCLES non-stalled cycles
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_trk_cnt_0 <= '0;
      r_trk_cnt_1 <= '0;
      r_trk_rd_0  <= '0;
      r_trk_rd_1  <= '0;
    end else if (!pipe_stall) begin
      if (w_iv0 && dec_is_load_0 && dec_rd_wen_0 && (dec_rd_addr_0 != '0)) begin
        r_trk_rd_0  <= dec_rd_addr_0;
        r_trk_cnt_0 <= CW'(LOAD_USE_CYCLES);
      end else if (r_trk_cnt_0 != '0) begin
        r_trk_cnt_0 <= r_trk_cnt_0 - 1'b1;
      end
      if (w_iv1 && dec_is_load_1 && dec_rd_wen_1 && (dec_rd_addr_1 != '0)) begin
        r_trk_rd_1  <= dec_rd_addr_1;
        r_trk_cnt_1 <= CW'(LOAD_USE_CYCLES);
      end else if (r_trk_cnt_1 != '0) begin
        r_trk_cnt_1 <= r_trk_cnt_1 - 1'b1;
      end
    end
  end

  assign issue_vld_0  = w_iv0;
  assign issue_vld_1  = w_iv1;
  assign dec_hold     = w_hold;
  assign split_active = !rst && (r_state == SCHED_SPLIT);
  assign dbg_state    = rst ? SCHED_PAIR : r_state;

endmodule
